// File: rtl/alu_multicycle.sv
// Execution-stage ALU: single-cycle logic/arith/shift/compare ops plus an
// optional iterative shift-add multiplier compiled in when ALU_MUL_EN is defined.
module alu_multicycle #(
  parameter int unsigned DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        alu_control,
  input  logic [DATA_W-1:0] alu_in_0,
  input  logic [DATA_W-1:0] alu_in_1,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [DATA_W-1:0] alu_out,
  output logic              zero_flag,
  output logic              valid_out
);

  localparam int unsigned SH_W = $clog2(DATA_W);

  localparam logic [3:0] OP_AND = 4'd0;
  localparam logic [3:0] OP_OR  = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SLL = 4'd3;
  localparam logic [3:0] OP_SRL = 4'd4;
  localparam logic [3:0] OP_SUB = 4'd6;
  localparam logic [3:0] OP_SLT = 4'd7;

  logic [SH_W-1:0]   shamt;
  logic [DATA_W-1:0] op_result;

  assign shamt = alu_in_1[SH_W-1:0];

  always_comb begin
    op_result = '0;
    case (alu_control)
      OP_AND:  op_result = alu_in_0 & alu_in_1;
      OP_OR:   op_result = alu_in_0 | alu_in_1;
      OP_ADD:  op_result = alu_in_0 + alu_in_1;
      OP_SLL:  op_result = alu_in_0 << shamt;
      OP_SRL:  op_result = alu_in_0 >> shamt;
      OP_SUB:  op_result = alu_in_0 - alu_in_1;
      OP_SLT:  op_result = {{(DATA_W-1){1'b0}}, ($signed(alu_in_0) < $signed(alu_in_1))};
      default: op_result = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;

  typedef enum logic {IDLE, MUL} state_e;

  state_e            state;
  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_next;
  logic [SH_W-1:0]   count;

  assign ready_out = (state == IDLE);
  assign acc_next  = acc + (mplier[0] ? mcand : '0);
`else
  assign ready_out = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_out   <= '0;
      zero_flag <= 1'b1;
      valid_out <= 1'b0;
`ifdef ALU_MUL_EN
      state     <= IDLE;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      count     <= '0;
`endif
    end else begin
      valid_out <= 1'b0;
`ifdef ALU_MUL_EN
      if (state == MUL) begin
        acc    <= acc_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        count  <= count + 1'b1;
        if (count == SH_W'(DATA_W - 1)) begin
          alu_out   <= acc_next;
          zero_flag <= (acc_next == '0);
          valid_out <= 1'b1;
          state     <= IDLE;
        end
      end else if (valid_in && (alu_control == OP_MUL)) begin
        // Bit 0 of the multiplier is consumed on the accept edge so all
        // DATA_W partial products fit in DATA_W edges including the accept.
        acc    <= alu_in_1[0] ? alu_in_0 : '0;
        mcand  <= alu_in_0 << 1;
        mplier <= alu_in_1 >> 1;
        count  <= SH_W'(1);
        state  <= MUL;
      end else
`endif
      if (valid_in) begin
        alu_out   <= op_result;
        zero_flag <= (op_result == '0);
        valid_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: directed and random ops against an
// arithmetic reference model; follows ALU_MUL_EN to pick the expected MUL behaviour.
module tb_alu_multicycle;

  localparam int unsigned W = 64;
`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   alu_control = '0;
  logic [W-1:0] alu_in_0 = '0;
  logic [W-1:0] alu_in_1 = '0;
  logic         valid_in = 1'b0;
  logic         ready_out;
  logic [W-1:0] alu_out;
  logic         zero_flag;
  logic         valid_out;

  int total = 0;
  int bad   = 0;

  alu_multicycle #(.DATA_W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_control(alu_control),
    .alu_in_0   (alu_in_0),
    .alu_in_1   (alu_in_1),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .alu_out    (alu_out),
    .zero_flag  (zero_flag),
    .valid_out  (valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a + b;
      4'd3: return a << (b % W);
      4'd4: return a >> (b % W);
      4'd6: return a - b;
      4'd7: return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      4'd8: return MUL_EN ? a * b : W'(0);
      default: return W'(0);
    endcase
  endfunction

  function automatic int ref_lat(input logic [3:0] op);
    return (MUL_EN && op == 4'd8) ? int'(W) : 1;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom};
  endfunction

  // Issue one request and wait (bounded) for its valid_out; reports what was seen.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] res, output logic zf, output int lat,
                       output int busy);
    alu_control = op;
    alu_in_0    = a;
    alu_in_1    = b;
    valid_in    = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat  = 1;
    busy = 0;
    while (valid_out !== 1'b1 && lat < 200) begin
      if (ready_out !== 1'b1) busy++;
      @(posedge clk); #1;
      lat++;
    end
    res = alu_out;
    zf  = zero_flag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (alu_out !== '0) begin bad++; $display("FAIL reset_alu_out: got %h want 0", alu_out); end
    total++; if (zero_flag !== 1'b1) begin bad++; $display("FAIL reset_zero_flag: got %b want 1", zero_flag); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready_out: got %b want 1", ready_out); end
    rst = 1'b0;
  endtask

  logic [3:0]   dir_op[7] = '{4'd2, 4'd6, 4'd7, 4'd3, 4'd4, 4'd9, 4'd5};
  logic [W-1:0] dir_a[7]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                              64'h8000_0000_0000_0000, 64'h1234, 64'hDEAD};
  logic [W-1:0] dir_b[7]  = '{64'd1, 64'd7, 64'd1, 64'd65, 64'd63, 64'h55, 64'h77};

  task automatic test_single_cycle();
    logic [W-1:0] res, exp;
    logic zf;
    int lat, busy;
    for (int i = 0; i < 7; i++) begin
      exp = ref_op(dir_op[i], dir_a[i], dir_b[i]);
      do_op(dir_op[i], dir_a[i], dir_b[i], res, zf, lat, busy);
      total++; if (res !== exp) begin bad++; $display("FAIL single_result[%0d] op=%0d: got %h want %h", i, dir_op[i], res, exp); end
      total++; if (zf !== (exp == '0)) begin bad++; $display("FAIL single_zero[%0d]: got %b want %b", i, zf, exp == '0); end
      total++; if (lat != 1) begin bad++; $display("FAIL single_latency[%0d]: got %0d want 1", i, lat); end
      total++; if (busy != 0) begin bad++; $display("FAIL single_ready[%0d]: got %0d busy cycles want 0", i, busy); end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] res, exp, a, b;
    logic zf;
    int lat, busy;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: begin a = 64'd6; b = 64'd7; end
        1: begin a = 64'h1_0000_0000; b = 64'h1_0000_0000; end
        2: begin a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; end
        default: begin a = rand_word(); b = rand_word(); end
      endcase
      exp = ref_op(4'd8, a, b);
      do_op(4'd8, a, b, res, zf, lat, busy);
      total++; if (res !== exp) begin bad++; $display("FAIL mul_result[%0d]: got %h want %h", i, res, exp); end
      total++; if (zf !== (exp == '0)) begin bad++; $display("FAIL mul_zero[%0d]: got %b want %b", i, zf, exp == '0); end
      total++; if (lat != ref_lat(4'd8)) begin bad++; $display("FAIL mul_latency[%0d]: got %0d want %0d", i, lat, ref_lat(4'd8)); end
      total++; if (busy != ref_lat(4'd8) - 1) begin bad++; $display("FAIL mul_busy[%0d]: got %0d want %0d", i, busy, ref_lat(4'd8) - 1); end
    end
  endtask

  task automatic test_mul_handshake();
    logic [W-1:0] exp;
    int lat;
    exp = ref_op(4'd8, 64'd9, 64'd11);
    alu_control = 4'd8; alu_in_0 = 64'd9; alu_in_1 = 64'd11; valid_in = 1'b1;
    @(posedge clk); #1;
    alu_control = 4'd2; alu_in_0 = 64'd1; alu_in_1 = 64'd1;
    lat = 1;
    while (valid_out !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    total++; if (lat != ref_lat(4'd8)) begin bad++; $display("FAIL hs_mul_latency: got %0d want %0d", lat, ref_lat(4'd8)); end
    total++; if (alu_out !== exp) begin bad++; $display("FAIL hs_mul_result: got %h want %h", alu_out, exp); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL hs_ready_at_done: got %b want 1", ready_out); end
    @(posedge clk); #1;
    valid_in = 1'b0;
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL hs_add_valid: got %b want 1", valid_out); end
    total++; if (alu_out !== 64'd2) begin bad++; $display("FAIL hs_add_result: got %h want 2", alu_out); end
    @(posedge clk); #1;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL hs_valid_drop: got %b want 0", valid_out); end
    total++; if (alu_out !== 64'd2) begin bad++; $display("FAIL hs_hold: got %h want 2", alu_out); end
  endtask

  task automatic test_operand_stability();
    int lat;
    alu_control = 4'd8; alu_in_0 = 64'd3; alu_in_1 = 64'd5; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = 1;
    while (valid_out !== 1'b1 && lat < 200) begin
      alu_in_0    = rand_word();
      alu_in_1    = rand_word();
      alu_control = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      lat++;
    end
    total++; if (alu_out !== ref_op(4'd8, 64'd3, 64'd5)) begin bad++; $display("FAIL stable_result: got %h want %h", alu_out, ref_op(4'd8, 64'd3, 64'd5)); end
    total++; if (lat != ref_lat(4'd8)) begin bad++; $display("FAIL stable_latency: got %0d want %0d", lat, ref_lat(4'd8)); end
  endtask

  task automatic test_random();
    logic [W-1:0] res, exp, a, b;
    logic [3:0] op;
    logic zf;
    int lat, busy;
    for (int i = 0; i < 40; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = rand_word();
      b  = rand_word();
      case ($urandom_range(0, 3))
        0: begin a = W'($urandom_range(0, 15)); b = W'($urandom_range(0, 15)); end
        1: b = a;
        2: a = {1'b1, a[W-2:0]};
        default: ;
      endcase
      exp = ref_op(op, a, b);
      do_op(op, a, b, res, zf, lat, busy);
      total++; if (res !== exp) begin bad++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, op, a, b, res, exp); end
      total++; if (zf !== (exp == '0)) begin bad++; $display("FAIL rand_zero[%0d]: got %b want %b", i, zf, exp == '0); end
      total++; if (lat != ref_lat(op)) begin bad++; $display("FAIL rand_latency[%0d] op=%0d: got %0d want %0d", i, op, lat, ref_lat(op)); end
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp, a, b;
    logic [3:0] op;
    for (int i = 0; i < 20; i++) begin
      do op = 4'($urandom_range(0, 15)); while (op == 4'd8);
      a = rand_word();
      b = (i % 3 == 0) ? a : rand_word();
      exp = ref_op(op, a, b);
      alu_control = op; alu_in_0 = a; alu_in_1 = b; valid_in = 1'b1;
      @(posedge clk); #1;
      total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, valid_out); end
      total++; if (alu_out !== exp) begin bad++; $display("FAIL b2b_result[%0d] op=%0d: got %h want %h", i, op, alu_out, exp); end
      total++; if (zero_flag !== (exp == '0)) begin bad++; $display("FAIL b2b_zero[%0d]: got %b want %b", i, zero_flag, exp == '0); end
    end
    valid_in = 1'b0;
    @(posedge clk); #1;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL b2b_valid_drop: got %b want 0", valid_out); end
  endtask

  task automatic test_reset_mid_mul();
    int spurious;
    alu_control = 4'd8; alu_in_0 = 64'd6; alu_in_1 = 64'd7; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rstmul_valid: got %b want 0", valid_out); end
    total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL rstmul_ready: got %b want 1", ready_out); end
    total++; if (alu_out !== '0) begin bad++; $display("FAIL rstmul_alu_out: got %h want 0", alu_out); end
    total++; if (zero_flag !== 1'b1) begin bad++; $display("FAIL rstmul_zero: got %b want 1", zero_flag); end
    spurious = 0;
    repeat (W + 6) begin
      @(posedge clk); #1;
      if (valid_out !== 1'b0) spurious++;
    end
    total++; if (spurious != 0) begin bad++; $display("FAIL rstmul_no_valid: got %0d pulses want 0", spurious); end
  endtask

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_mul_handshake();
    test_operand_stability();
    test_random();
    test_back_to_back();
    test_reset_mid_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    bad++;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
